// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences register-to-register moves over a shared
// tri-state bus. Commands queue in a small FIFO and retire in order
// through DRIVE -> LATCH -> TURN. eni comes from a falling-edge register
// so it can be used directly as a destination clock gate.
module bus_xfer_ctrl #(
  parameter int NREG  = 8,
  parameter int IDXW  = 3,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [IDXW-1:0] cmd_src,
  input  logic [IDXW-1:0] cmd_dst,
  output logic            cmd_ready,
  output logic [NREG-1:0] eno,
  output logic [NREG-1:0] eni,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IDXW:0]   NREG_W = (IDXW+1)'(NREG);
  localparam logic [NREG-1:0] ONE    = NREG'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, TURN} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] src, dst;
  logic [IDXW-1:0] q_src [DEPTH];
  logic [IDXW-1:0] q_dst [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, accept, bad_cmd, push, pop;

  assign empty     = (count == '0);
  assign cmd_ready = (count != CW'(DEPTH));
  assign accept    = cmd_valid & cmd_ready;
  assign bad_cmd   = (cmd_src == cmd_dst) | ({1'b0, cmd_src} >= NREG_W) |
                     ({1'b0, cmd_dst} >= NREG_W);
  assign push      = accept & ~bad_cmd;
  // The head is consumed whenever the sequencer is free to start a transfer.
  assign pop       = ~empty & ((state == IDLE) | (state == TURN));

  // FIFO storage; contents need no reset, the count guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr] <= cmd_src;
      q_dst[wr_ptr] <= cmd_dst;
    end
  end

  // FIFO pointers and occupancy; push+pop on one edge keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Current transfer indices and the reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      src <= '0;
      dst <= '0;
      err <= 1'b0;
    end else begin
      if (pop) begin
        src <= q_src[rd_ptr];
        dst <= q_dst[rd_ptr];
      end
      err <= accept & bad_cmd;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = DRIVE;
      DRIVE:   state_nx = LATCH;
      LATCH:   state_nx = TURN;
      TURN:    state_nx = pop ? DRIVE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    eno  = '0;
    done = 1'b0;
    busy = (state != IDLE) | ~empty;
    case (state)
      DRIVE, LATCH: eno = ONE << src;
      TURN:         done = 1'b1;
      default:      ;
    endcase
  end

  // Falling-edge enable: stable through every clk-high phase so it can gate
  // the destination clock; opens mid-LATCH and closes mid-TURN.
  always_ff @(negedge clk) begin
    if (rst) eni <= '0;
    else     eni <= (state == LATCH) ? (ONE << dst) : '0;
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: bus register model, in-order scoreboard,
// invariant and glitch monitors, directed scenarios.
`timescale 1ns/1ps
module tb_bus_xfer_ctrl;

  localparam int NREG = 8, IDXW = 4, DEPTH = 4;

  logic            clk, rst, cmd_valid, cmd_ready, busy, done, err;
  logic [IDXW-1:0] cmd_src, cmd_dst;
  logic [NREG-1:0] eno, eni;

  bus_xfer_ctrl #(.NREG(NREG), .IDXW(IDXW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_ready(cmd_ready), .eno(eno), .eni(eni),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (i == 2) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i);
  endfunction

  // Bus registers: eno selects the driver, eni-gated clock captures.
  logic        bus_init;
  logic [31:0] regs [NREG];
  logic [31:0] bus;
  always_comb begin
    bus = '0;
    for (int i = 0; i < NREG; i++) if (eno[i]) bus = regs[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bus_init)    regs[i] <= init_val(i);
      else if (eni[i]) regs[i] <= bus;
    end
  end

  typedef struct {logic [IDXW-1:0] s, d; logic [31:0] data;} xfer_t;
  xfer_t       sb[$];
  logic [31:0] exp_regs [NREG];
  int          cyc = 0, done_cnt = 0, acc_cnt = 0;
  int          done_times[$];
  bit          eni_seen, ready_low_seen;
  logic [NREG-1:0] last_eno, prev_eno;

  // Scoreboard and invariant monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    chk("eno_onehot", 32'($countones(eno) <= 1), 32'd1);
    chk("eni_onehot", 32'($countones(eni) <= 1), 32'd1);
    chk("dead_cycle", 32'(prev_eno != '0 && eno != '0 && eno != prev_eno), 32'd0);
    prev_eno = eno;
    if (eno != '0) last_eno = eno;
    if (eni != '0) eni_seen = 1'b1;
    if (!cmd_ready) ready_low_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (sb.size() == 0) chk("done_unexp", 32'(done), 32'd0);
      else begin
        xfer_t x;
        x = sb.pop_front();
        chk("done_src", 32'(last_eno), 32'(8'(1) << x.s));
        chk("done_eni", 32'(eni), 32'(8'(1) << x.d));
        chk("done_eno0", 32'(eno), 32'd0);
        chk("done_data", regs[x.d], x.data);
      end
    end
  end

  // Glitch monitor: eni must hold its rising-edge value through clk-high.
  always @(posedge clk) begin
    logic [NREG-1:0] e0;
    e0 = eni;
    #($urandom_range(1, 4));
    chk("eni_glitch", 32'(eni), 32'(e0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IDXW-1:0] s, input logic [IDXW-1:0] d, input bit sb_en);
    bit acc, rej;
    int n;
    xfer_t x;
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      acc = cmd_ready;
      tick();
      n++;
    end
    chk("accept", 32'(acc), 32'd1);
    rej = (s == d) || (s >= NREG) || (d >= NREG);
    chk("err", 32'(err), 32'(rej));
    if (acc && !rej && sb_en) begin
      x.s = s; x.d = d; x.data = exp_regs[s];
      exp_regs[d] = x.data;
      sb.push_back(x);
      acc_cnt++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int d0, a0;
    for (int i = 0; i < NREG; i++) exp_regs[i] = init_val(i);
    rst = 1'b1; bus_init = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
    eni_seen = 1'b0; ready_low_seen = 1'b0; last_eno = '0; prev_eno = '0;
    tick(); tick();
    bus_init = 1'b0;
    tick();
    chk("rst_eno", 32'(eno), 32'd0);
    chk("rst_eni", 32'(eni), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single transfer 2 -> 5 with exact latency.
    push(4'd2, 4'd5, 1'b1);              // now E0+1
    cmd_valid = 1'b0;
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_eno_e0", 32'(eno), 32'd0);
    tick();                              // E1+1 DRIVE
    chk("s_eno_e1", 32'(eno), 32'h04);
    tick();                              // E2+1 LATCH
    chk("s_eno_e2", 32'(eno), 32'h04);
    chk("s_eni_e2", 32'(eni), 32'd0);
    @(negedge clk); #1;
    chk("s_eni_neg", 32'(eni), 32'h20);
    tick();                              // E3+1 TURN
    chk("s_done", 32'(done), 32'd1);
    chk("s_data", regs[5], 32'hDEADBEEF);
    tick();                              // E4+1
    chk("s_done_e4", 32'(done), 32'd0);
    chk("s_busy_e4", 32'(busy), 32'd0);
    @(negedge clk); #1;
    chk("s_eni_off", 32'(eni), 32'd0);
    tick();

    // Back-to-back: three done pulses exactly 3 cycles apart.
    done_times.delete();
    push(4'd0, 4'd1, 1'b1);
    push(4'd1, 4'd2, 1'b1);
    push(4'd2, 4'd3, 1'b1);
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_count", 32'(done_times.size()), 32'd3);
    if (done_times.size() == 3) begin
      chk("b2b_gap1", 32'(done_times[1] - done_times[0]), 32'd3);
      chk("b2b_gap2", 32'(done_times[2] - done_times[1]), 32'd3);
    end

    // Full FIFO: DEPTH+2 commands with valid held.
    d0 = done_cnt; a0 = acc_cnt; ready_low_seen = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++)
      push(4'(i % NREG), 4'((i + 3) % NREG), 1'b1);
    cmd_valid = 1'b0;
    wait_idle();
    chk("full_ready_low", 32'(ready_low_seen), 32'd1);
    chk("full_accepted", 32'(acc_cnt - a0), 32'(DEPTH + 2));
    chk("full_done", 32'(done_cnt - d0), 32'(acc_cnt - a0));

    // Rejects: src==dst and out-of-range source.
    push(4'd4, 4'd4, 1'b1);
    push(4'd9, 4'd1, 1'b1);
    cmd_valid = 1'b0;
    chk("rej_busy", 32'(busy), 32'd0);
    chk("rej_eno", 32'(eno), 32'd0);
    tick();
    chk("rej_err_off", 32'(err), 32'd0);
    chk("rej_eni", 32'(eni), 32'd0);
    chk("rej_busy2", 32'(busy), 32'd0);

    // Reset at the edge that ends DRIVE: nothing captured, queue flushed.
    d0 = done_cnt;
    push(4'd3, 4'd6, 1'b0);              // E0+1
    push(4'd1, 4'd7, 1'b0);              // E1+1, DRIVE of 3->6
    cmd_valid = 1'b0;
    chk("mr_drive", 32'(eno), 32'h08);
    eni_seen = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_eno", 32'(eno), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    repeat (8) tick();
    chk("mr_eni_seen", 32'(eni_seen), 32'd0);
    chk("mr_dst6", regs[6], exp_regs[6]);
    chk("mr_dst7", regs[7], exp_regs[7]);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_no_done", 32'(done_cnt - d0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
